seg7_scan_driver: RTL

Consumer side of the CPU syscall display path: accepts 32-bit display words written by the pipeline's write-back stage and time-multiplexes them as 8 hex digits onto the board's 8-digit common-anode seven-segment display. Writes are double-buffered so the shown value changes only at a frame boundary, which prevents tearing. Sits beside the CPU top and drives digitalLocation/digitalStates.

---
 rtl/seg7_scan_driver.sv | 57 +++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: double-buffered 8-digit hex scan driver for a common-anode seven-segment display
module seg7_scan_driver #(
   parameter int DIV      = 100000,
   parameter bit BLANK_LZ = 1'b0
) (
   input  logic        Clock,
   input  logic        rst_n,
   input  logic        disp_we,
   input  logic [31:0] disp_data,
   input  logic        disp_en,
   input  logic [7:0]  dp_mask,
   output logic        disp_pending,
   output logic        frame_done,
   output logic [7:0]  digitalLocation,
   output logic [7:0]  digitalStates
);
   localparam int W = $clog2(DIV);
   localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [W-1:0] presc;
   logic [2:0]   idx;
   logic [31:0]  active, pend_data;
   logic [7:0]   nz;
   logic [3:0]   nib;
   logic         tick, boundary, blank;
   for (genvar i = 0; i < 8; i++) begin : g_nz
      assign nz[i] = |active[4*i +: 4];
   end
   always_comb begin
      tick     = presc == W'(DIV - 1);
      boundary = tick && idx == 3'd7;
      nib      = active[{idx, 2'b00} +: 4];
      // a digit is leading-zero when it and every digit above it are zero
      blank    = BLANK_LZ && idx != 3'd0 && (nz >> idx) == 8'd0;
   end
   always_ff @(posedge Clock or negedge rst_n) begin
      if (!rst_n) begin
         presc           <= '0;
         idx             <= 3'd0;
         active          <= 32'd0;
         pend_data       <= 32'd0;
         disp_pending    <= 1'b0;
         frame_done      <= 1'b0;
         digitalLocation <= 8'hFF;
         digitalStates   <= 8'hFF;
      end else begin
         presc           <= tick ? '0 : presc + 1'b1;
         idx             <= tick ? idx + 3'd1 : idx;
         pend_data       <= disp_we ? disp_data : pend_data;
         disp_pending    <= disp_we | (disp_pending & ~boundary);
         active          <= (boundary && disp_pending) ? pend_data : active;
         frame_done      <= boundary;
         digitalLocation <= disp_en ? ~(8'd1 << idx) : 8'hFF;
         digitalStates   <= {~dp_mask[idx], blank ? 7'h7F : SEG[nib]};
      end
   end
endmodule
